conv_accum: RTL and testbench

- Sits directly downstream of the 25-tap convolution adder tree.
- Accumulates the tree's per-input-channel partial sums for one output pixel, adds the output-channel bias, saturates to DWIDTH and optionally applies ReLU.
- Produces one output-feature-map value per accumulation group, with a valid strobe, for the pooling/write-back stage.
- Two-stage register pipeline with a two-state FSM and a sticky protocol-error flag.

---
 rtl/conv_accum.sv | 110 +++++++++++
 tb/tb_conv_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conv_accum.sv
// Per-pixel channel accumulator behind the convolution adder tree: adds bias,
// sums partial sums over a group, then saturates and optionally rectifies.
module conv_accum #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 24
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              in_valid,
  input  logic              first,
  input  logic              last,
  input  logic [DWIDTH-1:0] fmap_in,
  input  logic [DWIDTH-1:0] bias,
  input  logic              relu_en,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              proto_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [AWIDTH-1:0] SAT_MAX =
    {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] SAT_MIN =
    {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  state_t                    state_reg, state_next;
  logic signed [AWIDTH-1:0]  acc_reg, acc_next;
  logic signed [AWIDTH-1:0]  s2_sum_reg, s2_sum_next;
  logic                      s2_valid_reg, s2_valid_next;
  logic                      s2_relu_reg, s2_relu_next;
  logic                      err_reg, err_next;
  logic                      out_valid_reg;
  logic [DWIDTH-1:0]         out_data_reg, result;

  logic signed [AWIDTH-1:0]  fmap_ext, bias_ext, start_sum, cont_sum;

  assign fmap_ext  = {{(AWIDTH-DWIDTH){fmap_in[DWIDTH-1]}}, fmap_in};
  assign bias_ext  = {{(AWIDTH-DWIDTH){bias[DWIDTH-1]}}, bias};
  assign start_sum = bias_ext + fmap_ext;
  assign cont_sum  = acc_reg + fmap_ext;

  // A first beat always opens a fresh group, even if one was still open.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    s2_sum_next   = s2_sum_reg;
    s2_valid_next = 1'b0;
    s2_relu_next  = s2_relu_reg;
    err_next      = err_reg;
    if (in_valid) begin
      if (first) begin
        if (state_reg == ACCUM) err_next = 1'b1;
        if (last) begin
          s2_sum_next   = start_sum;
          s2_valid_next = 1'b1;
          s2_relu_next  = relu_en;
          state_next    = IDLE;
        end else begin
          acc_next   = start_sum;
          state_next = ACCUM;
        end
      end else if (state_reg == IDLE) begin
        err_next = 1'b1;
      end else if (last) begin
        s2_sum_next   = cont_sum;
        s2_valid_next = 1'b1;
        s2_relu_next  = relu_en;
        state_next    = IDLE;
      end else begin
        acc_next = cont_sum;
      end
    end
  end

  // Clamp to the DWIDTH signed range, then zero negatives when rectifying.
  always_comb begin
    result = s2_sum_reg[DWIDTH-1:0];
    if (s2_sum_reg > SAT_MAX)      result = SAT_MAX[DWIDTH-1:0];
    else if (s2_sum_reg < SAT_MIN) result = SAT_MIN[DWIDTH-1:0];
    if (s2_relu_reg && result[DWIDTH-1]) result = '0;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      s2_sum_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_relu_reg   <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      s2_sum_reg    <= s2_sum_next;
      s2_valid_reg  <= s2_valid_next;
      s2_relu_reg   <= s2_relu_next;
      err_reg       <= err_next;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) out_data_reg <= result;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign proto_err = err_reg;

endmodule

// File: tb/tb_conv_accum.sv
// Scoreboard bench for conv_accum: directed cases plus random groups checked
// against an integer reference model of bias + channel sum, clamp and ReLU.
module tb_conv_accum;

  logic        clk = 1'b0;
  logic        xrst = 1'b1;
  logic        in_valid = 1'b0;
  logic        first = 1'b0;
  logic        last = 1'b0;
  logic [15:0] fmap_in = '0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   grp[$];

  conv_accum #(.DWIDTH(16), .AWIDTH(24)) dut (
    .clk(clk), .xrst(xrst), .in_valid(in_valid), .first(first), .last(last),
    .fmap_in(fmap_in), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer sum, clamp to 16-bit signed, optional ReLU.
  function automatic logic [15:0] model(input int s, input logic r);
    int v;
    v = s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (r && v < 0) v = 0;
    return v[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL out_timing: no out_valid by cycle %0d, required data %0d",
               sb[0].due, $signed(sb[0].data));
      void'(sb.pop_front());
    end
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: out_valid=1 data=%0d at cycle %0d, required none",
                 $signed(out_data), cyc);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL out_data: got %0d at cycle %0d, required %0d at cycle %0d",
                   $signed(out_data), cyc, $signed(e.data), e.due);
        end else begin
          $display("ok out_data=%0d at cycle %0d", $signed(out_data), cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok %s=%0d", name, act);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input int d, input int b, input logic r);
    in_valid = v; first = f; last = l;
    fmap_in = 16'(d); bias = 16'(b); relu_en = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), int'($urandom), int'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    xrst = 1'b1;
    idle(1);
    xrst = 1'b0;
  endtask

  // Sends grp[] as one group; bias only on the first beat and relu only on the
  // last beat matter, so other beats carry random values in those fields.
  task automatic send_group(input int b, input logic r, input int bub_pct);
    int   n, sum;
    exp_t e;
    n = grp.size();
    sum = b;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(99)) < bub_pct) idle(1);
      sum += grp[i];
      drive(1'b1, i == 0, i == n - 1, grp[i],
            (i == 0) ? b : int'($urandom),
            (i == n - 1) ? r : 1'($urandom));
    end
    e.data = model(sum, r);
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  initial begin
    idle(2);
    xrst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_proto_err", int'(proto_err), 0);

    grp = '{100};               send_group(20, 1'b0, 0);   // 120
    idle(2);
    grp = '{1000, -3000, 500};  send_group(-100, 1'b0, 100); // -1600
    idle(1);
    grp = '{1000, -3000, 500};  send_group(-100, 1'b1, 100); // 0
    idle(2);
    grp = '{30000, 30000, 30000, 30000};     send_group(0, 1'b0, 0);  // 32767
    grp = '{-30000, -30000, -30000, -30000}; send_group(-5, 1'b0, 0); // -32768
    idle(3);
    check("sat_proto_err", int'(proto_err), 0);

    grp = '{7};    send_group(1, 1'b0, 0);  // 8
    grp = '{5, 6}; send_group(0, 1'b0, 0);  // 11
    idle(3);

    // Reset two beats into a group: no output may follow for it.
    drive(1'b1, 1'b1, 1'b0, 400, 9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 400, 0, 1'b0);
    do_reset();
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_data", int'(out_data), 0);
    idle(4);
    grp = '{3}; send_group(0, 1'b0, 0);     // 3
    idle(3);

    drive(1'b1, 1'b0, 1'b0, 77, 0, 1'b0);   // non-first beat in IDLE
    idle(3);
    check("idle_nonfirst_proto_err", int'(proto_err), 1);
    drive(1'b1, 1'b1, 1'b0, 50, 0, 1'b0);   // abandoned partial
    grp = '{10, 20}; send_group(0, 1'b0, 0); // 30
    idle(4);
    check("restart_proto_err", int'(proto_err), 1);
    do_reset();
    check("cleared_proto_err", int'(proto_err), 0);

    for (int g = 0; g < 40; g++) begin
      int len;
      len = int'($urandom_range(1, 8));
      grp.delete();
      for (int k = 0; k < len; k++) grp.push_back(int'($urandom_range(0, 65535)) - 32768);
      send_group(int'($urandom_range(0, 65535)) - 32768, 1'($urandom), 30);
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    check("random_proto_err", int'(proto_err), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
